alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the RV32I execute stage; successor to the 2-bit-opSel combinational ALU.
//  Accepts one operation per valid/ready handshake and returns a registered result with Z/error flags.
//  Shifts run iteratively (1 bit/cycle) unless the barrel shifter is compiled in.
//  Sits between the operand mux (rs1 / rs2-or-imm) and the writeback register.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; power of two, >= 8
//  SHAMT_W     $clog2(DATA_WIDTH)  shift-amount width; derived, do not override
// PORTS
//  clk        in   1           rising-edge clock
//  rstN       in   1           asynchronous active-low reset
//  flush      in   1           synchronous abort of any in-flight/held op
//  in_valid   in   1           operands + op valid
//  in_ready   out  1           ALU can accept (state IDLE)
//  op         in   4           alu_op_t (alu_definitions)
//  bus_a      in   DATA_WIDTH  rs1
//  bus_b      in   DATA_WIDTH  rs2 or immediate
//  out_valid  out  1           result valid, held until out_ready
//  out_ready  in   1           consumer takes result
//  out        out  DATA_WIDTH  result
//  Z          out  1           out == 0
//  error      out  1           signed overflow (ADD/SUB) or illegal op
// BEHAVIOUR
//  - Reset (rstN=0, async): state=IDLE; out=0, out_valid=0, Z=0, error=0; in_ready=1 after release.
//  - FSM IDLE -> (accept, non-shift) DONE; IDLE -> (accept, shift, shamt>0) SHIFT; SHIFT -> (count==0) DONE;
//    DONE -> (out_ready) IDLE. Accept = in_valid & in_ready; in_ready = (state==IDLE) only.
//  - Operands and op latched on accept; later input changes ignored.
//  - Non-shift latency 1: out_valid rises the cycle after accept.
//  - Shifts: shamt = bus_b[SHAMT_W-1:0]; upper bits ignored. Latency shamt+1 (shamt=0 -> 1 cycle, goes straight to DONE).
//  - Ops: ADD/SUB wrap mod 2^DATA_WIDTH; error = signed overflow. SLL/SRL logical, SRA sign-fills.
//    AND/OR/XOR bitwise. SLT signed, SLTU unsigned: out = 1 if a<b else 0 (zero-extended).
//    LUI: out = bus_b (immediate pre-shifted upstream). Undefined op code: out = bus_a, error=1.
//  - error=0 for all legal ops except ADD/SUB overflow. Z computed from final result.
//  - DONE: out/Z/error/out_valid stable until out_ready; out_valid drops the cycle after handshake.
//  - Max throughput: one op per 2 cycles (no accept while DONE).
//  - flush: any state -> IDLE next cycle, out_valid=0; flush has priority over accept and out_ready.
//  - Reset mid-SHIFT: op discarded, outputs to reset values immediately.
// CONFIGURATION
//  ALU_BARREL_SHIFT_EN defined: shifts computed combinationally, latency 1 like all ops; SHIFT state unused.
//  Not defined: iterative shifter, latency shamt+1; smaller area.
// STRUCTURE
//  Package alu_definitions: typedef enum logic [3:0] alu_op_t {ADD,SUB,SLL,SRL,SRA,AND,OR,XOR,SLT,SLTU,LUI};
//    typedef enum alu_state_t {IDLE,SHIFT,DONE}.
//  Sub-module alu_mc_shifter: shift datapath + down-counter (both build variants), start/done handshake to FSM.
// TESTING (DATA_WIDTH=32, both macro settings)
//  1. ADD 0x7FFF_FFFF + 0x1 -> out=0x8000_0000, error=1, Z=0, out_valid 1 cycle after accept.
//  2. SUB 0x5 - 0x5 -> out=0, Z=1, error=0; SLTU 0x1 vs 0xFFFF_FFFF -> out=1; SLT same -> out=0.
//  3. SLL 0x1 by bus_b=0x3F (shamt 31) -> out=0x8000_0000 after 32 cycles (1 cycle with ALU_BARREL_SHIFT_EN).
//  4. SRA 0x8000_0000 by 4 -> 0xF800_0000; SRL same -> 0x0800_0000; shamt 0 -> bus_a, latency 1.
//  5. out_ready=0 for 5 cycles: out/Z/error stable, in_ready=0, new in_valid ignored; release -> IDLE.
//  6. rstN low mid-shift (count 10) -> out_valid=0, out=0 immediately; flush in DONE -> IDLE, result dropped.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: op codes, FSM states, shift kinds.
// No logic here; consumed by alu_mc and alu_mc_shifter.
// Op codes 11..15 are deliberately left unassigned and decode as illegal.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SRL  = 4'd3,
        SRA  = 4'd4,
        AND  = 4'd5,
        OR   = 4'd6,
        XOR  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9,
        LUI  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        SH_LEFT      = 2'd0,
        SH_RIGHT_LOG = 2'd1,
        SH_RIGHT_ARI = 2'd2
    } shift_kind_t;

    function automatic logic is_shift(input alu_op_t op);
        return (op == SLL) || (op == SRL) || (op == SRA);
    endfunction

endpackage

// File: rtl/alu_mc_shifter.sv
// Shift datapath for alu_mc: iterative 1 bit/cycle, or combinational with ALU_BARREL_SHIFT_EN.
// Latency: iterative done after shamt step cycles (counter loaded with shamt-1); barrel done with start.
// No backpressure: the parent FSM only starts a shift from IDLE and waits for o_done.
module alu_mc_shifter
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  i_flush,
    input  logic                  i_start,
    input  logic [1:0]            i_kind,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [SHAMT_W-1:0]    i_shamt,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

`ifdef ALU_BARREL_SHIFT_EN

    // Control inputs are only needed by the iterative variant.
    logic w_unused;
    assign w_unused = ^{clk, rstN, i_flush};

    assign o_done = i_start;

    // Whole shift resolved in the accept cycle.
    always_comb begin
        o_result = i_a;
        case (i_kind)
            SH_LEFT:      o_result = i_a << i_shamt;
            SH_RIGHT_LOG: o_result = i_a >> i_shamt;
            SH_RIGHT_ARI: o_result = $signed(i_a) >>> i_shamt;
            default:      o_result = i_a;
        endcase
    end

`else

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    logic                  r_busy;
    logic [SHAMT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_val;
    logic [1:0]            r_kind;
    logic [DATA_WIDTH-1:0] w_step;

    // One-bit step of the working value; exposed so the last step lands in the result directly.
    always_comb begin
        w_step = r_val;
        case (r_kind)
            SH_LEFT:      w_step = {r_val[DATA_WIDTH-2:0], 1'b0};
            SH_RIGHT_LOG: w_step = {1'b0, r_val[DATA_WIDTH-1:1]};
            SH_RIGHT_ARI: w_step = {r_val[DATA_WIDTH-1], r_val[DATA_WIDTH-1:1]};
            default:      w_step = r_val;
        endcase
    end

    // Load on start (counter holds remaining steps minus one), then shift and count down.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_val  <= '0;
            r_kind <= 2'd0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= i_shamt - CNT_ONE;
            r_val  <= i_a;
            r_kind <= i_kind;
        end else if (r_busy) begin
            r_val <= w_step;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    assign o_done   = r_busy && (r_cnt == '0);
    assign o_result = w_step;

`endif

endmodule

// File: rtl/alu_mc.sv
// RV32I execute ALU, one op per valid/ready handshake; ALU_BARREL_SHIFT_EN selects combinational shifts.
// Latency 1 for all ops; iterative shifts take shamt+1 (shamt 0 takes 1).
// in_ready only in IDLE; result held in DONE until out_ready; flush aborts anything in flight.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] bus_a,
    input  logic [DATA_WIDTH-1:0] bus_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  Z,
    output logic                  error
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int MSB     = DATA_WIDTH - 1;

    alu_state_t            r_state;
    alu_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_z;
    logic                  r_err;

    alu_op_t               w_op;
    logic                  w_accept;
    logic                  w_is_shift;
    logic                  w_shift_now;
    logic [SHAMT_W-1:0]    w_shamt;
    logic [1:0]            w_kind;
    logic                  w_sh_start;
    logic                  w_sh_done;
    logic [DATA_WIDTH-1:0] w_sh_result;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_err;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_load_res;
    logic                  w_load_err;

    assign w_op       = alu_op_t'(op);
    assign w_accept   = in_valid && in_ready;
    assign w_is_shift = is_shift(w_op);
    assign w_shamt    = bus_b[SHAMT_W-1:0];
    assign w_kind     = (w_op == SLL) ? SH_LEFT :
                        (w_op == SRL) ? SH_RIGHT_LOG : SH_RIGHT_ARI;
    assign w_sum      = bus_a + bus_b;
    assign w_diff     = bus_a - bus_b;

`ifdef ALU_BARREL_SHIFT_EN
    assign w_shift_now = 1'b0;
    assign w_sh_start  = w_accept && w_is_shift;
`else
    // A zero shift amount needs no stepping and completes like any other op.
    assign w_shift_now = (w_shamt != '0);
    assign w_sh_start  = w_accept && w_is_shift && w_shift_now;
`endif

    alu_mc_shifter #(
        .DATA_WIDTH(DATA_WIDTH),
        .SHAMT_W   (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rstN    (rstN),
        .i_flush (flush),
        .i_start (w_sh_start),
        .i_kind  (w_kind),
        .i_a     (bus_a),
        .i_shamt (w_shamt),
        .o_done  (w_sh_done),
        .o_result(w_sh_result)
    );

    // Single-cycle result from the operands presented at accept.
    always_comb begin
        w_res = bus_a;
        w_err = 1'b0;
        case (w_op)
            ADD: begin
                w_res = w_sum;
                w_err = (bus_a[MSB] == bus_b[MSB]) && (w_sum[MSB] != bus_a[MSB]);
            end
            SUB: begin
                w_res = w_diff;
                w_err = (bus_a[MSB] != bus_b[MSB]) && (w_diff[MSB] != bus_a[MSB]);
            end
`ifdef ALU_BARREL_SHIFT_EN
            SLL, SRL, SRA: w_res = w_sh_result;
`else
            SLL, SRL, SRA: w_res = bus_a;
`endif
            AND:  w_res = bus_a & bus_b;
            OR:   w_res = bus_a | bus_b;
            XOR:  w_res = bus_a ^ bus_b;
            SLT:  w_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus_a) < $signed(bus_b))};
            SLTU: w_res = {{(DATA_WIDTH-1){1'b0}}, (bus_a < bus_b)};
            LUI:  w_res = bus_b;
            default: begin
                w_res = bus_a;
                w_err = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; flush overrides accept and out_ready.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_nxt = (w_is_shift && w_shift_now) ? SHIFT : DONE;
                SHIFT:   if (w_sh_done) w_state_nxt = DONE;
                DONE:    if (out_ready) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs are pure state decodes.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    assign w_load     = (w_state_nxt == DONE) && (r_state != DONE);
    assign w_load_res = (r_state == SHIFT) ? w_sh_result : w_res;
    assign w_load_err = (r_state == SHIFT) ? 1'b0 : w_err;

    // Result registers capture on entry to DONE and hold until the next op.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_out <= '0;
            r_z   <= 1'b0;
            r_err <= 1'b0;
        end else if (w_load) begin
            r_out <= w_load_res;
            r_z   <= (w_load_res == '0);
            r_err <= w_load_err;
        end
    end

    assign out   = r_out;
    assign Z     = r_z;
    assign error = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (DATA_WIDTH=32), either shifter build.
// Expected results are queued when an op is issued and popped when out_valid appears.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_alu_mc;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif
    localparam int     TMO  = 100;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0;
    logic        rstN, flush, in_valid, in_ready, out_valid, out_ready, Z, error;
    logic [3:0]  op;
    logic [31:0] bus_a, bus_b, out;

    always #5 clk = ~clk;

    alu_mc #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstN(rstN), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .bus_a(bus_a), .bus_b(bus_b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .Z(Z), .error(error)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        err;
        int          lat_iter;
    } vec_t;

    exp_t sb_q[$];
    int   n_err = 0;
    int   n_chk = 0;

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic z, input logic e, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = r; v.z = z; v.err = e; v.lat_iter = lat;
        return v;
    endfunction

    // Reference behaviour, written from the ISA definition using wide signed arithmetic.
    function automatic exp_t model(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, t;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        e.res = a; e.err = 1'b0; e.lat = 1;
        case (mop)
            4'd0: begin e.res = a + b; t = sa + sb; e.err = (t > SMAX) || (t < SMIN); end
            4'd1: begin e.res = a - b; t = sa - sb; e.err = (t > SMAX) || (t < SMIN); end
            4'd2: e.res = a << sh;
            4'd3: e.res = a >> sh;
            4'd4: e.res = $signed(a) >>> sh;
            4'd5: e.res = a & b;
            4'd6: e.res = a | b;
            4'd7: e.res = a ^ b;
            4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd10: e.res = b;
            default: begin e.res = a; e.err = 1'b1; end
        endcase
        if (!BARREL && (mop >= 4'd2) && (mop <= 4'd4) && (sh != 0)) e.lat = sh + 1;
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Issue one op from IDLE, scramble inputs after accept, wait (bounded) for the result, retire it.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] g_res, output logic g_z, output logic g_err, output int g_lat);
        @(negedge clk);
        op = o; bus_a = a; bus_b = b; in_valid = 1'b1;
        @(posedge clk);
        g_lat = 1;
        @(negedge clk);
        in_valid = 1'b0; op = 4'hF; bus_a = ~a; bus_b = ~b;
        while (!out_valid && g_lat < TMO) begin
            @(posedge clk);
            g_lat++;
            @(negedge clk);
        end
        g_res = out; g_z = Z; g_err = error;
        if (out_valid) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end else begin
            flush = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; bus_a = '0; bus_b = '0;
        repeat (2) @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_chk++; if (out !== 32'd0) begin n_err++; $display("FAIL reset_out got=%h want=0", out); end
        n_chk++; if ({Z, error} !== 2'b00) begin n_err++; $display("FAIL reset_flags got Z,err=%b want=00", {Z, error}); end
        rstN = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_arith();
        vec_t        vq[$];
        exp_t        e;
        logic [31:0] g_res;
        logic        g_z, g_err;
        int          g_lat;
        vq.push_back(mk(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1));
        vq.push_back(mk(4'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1));
        vq.push_back(mk(4'd9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1));
        vq.push_back(mk(4'd8, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1));
        vq.push_back(mk(4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1));
        vq.push_back(mk(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1));
        vq.push_back(mk(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1));
        vq.push_back(mk(4'd6, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1));
        vq.push_back(mk(4'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1, 1'b0, 1));
        vq.push_back(mk(4'd10, 32'h0000_1234, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1'b0, 1));
        vq.push_back(mk(4'd11, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 1'b1, 1));
        vq.push_back(mk(4'd15, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b1, 1));
        foreach (vq[i]) begin
            e.res = vq[i].res; e.z = vq[i].z; e.err = vq[i].err; e.lat = vq[i].lat_iter;
            sb_q.push_back(e);
            run_op(vq[i].op, vq[i].a, vq[i].b, g_res, g_z, g_err, g_lat);
            e = sb_q.pop_front();
            n_chk++; if (g_res !== e.res) begin n_err++; $display("FAIL arith[%0d] out got=%h want=%h", i, g_res, e.res); end
            n_chk++; if (g_z !== e.z) begin n_err++; $display("FAIL arith[%0d] Z got=%b want=%b", i, g_z, e.z); end
            n_chk++; if (g_err !== e.err) begin n_err++; $display("FAIL arith[%0d] error got=%b want=%b", i, g_err, e.err); end
            n_chk++; if (g_lat !== e.lat) begin n_err++; $display("FAIL arith[%0d] latency got=%0d want=%0d", i, g_lat, e.lat); end
        end
    endtask

    task automatic test_shift();
        vec_t        vq[$];
        exp_t        e;
        logic [31:0] g_res;
        logic        g_z, g_err;
        int          g_lat;
        vq.push_back(mk(4'd2, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1'b0, 32));
        vq.push_back(mk(4'd4, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 5));
        vq.push_back(mk(4'd3, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 5));
        vq.push_back(mk(4'd2, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1));
        vq.push_back(mk(4'd4, 32'h7FFF_FFFF, 32'hFFFF_FFE1, 32'h3FFF_FFFF, 1'b0, 1'b0, 2));
        vq.push_back(mk(4'd3, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 2));
        vq.push_back(mk(4'd4, 32'hC000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 32));
        foreach (vq[i]) begin
            e.res = vq[i].res; e.z = vq[i].z; e.err = vq[i].err;
            e.lat = BARREL ? 1 : vq[i].lat_iter;
            sb_q.push_back(e);
            run_op(vq[i].op, vq[i].a, vq[i].b, g_res, g_z, g_err, g_lat);
            e = sb_q.pop_front();
            n_chk++; if (g_res !== e.res) begin n_err++; $display("FAIL shift[%0d] out got=%h want=%h", i, g_res, e.res); end
            n_chk++; if (g_z !== e.z) begin n_err++; $display("FAIL shift[%0d] Z got=%b want=%b", i, g_z, e.z); end
            n_chk++; if (g_err !== e.err) begin n_err++; $display("FAIL shift[%0d] error got=%b want=%b", i, g_err, e.err); end
            n_chk++; if (g_lat !== e.lat) begin n_err++; $display("FAIL shift[%0d] latency got=%0d want=%0d", i, g_lat, e.lat); end
        end
    endtask

    task automatic test_hold();
        logic saw;
        @(negedge clk);
        op = 4'd0; bus_a = 32'h7FFF_FFFF; bus_b = 32'h1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_first_valid got=%b want=1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            op = 4'd1; bus_a = 32'h5 + c; bus_b = 32'h5; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n_chk++;
            if ({out_valid, in_ready, out, Z, error} !== {1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL hold_cycle%0d got valid=%b rdy=%b out=%h Z=%b err=%b want 1 0 80000000 0 1",
                         c, out_valid, in_ready, out, Z, error);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_chk++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL hold_release got valid,rdy=%b want=01", {out_valid, in_ready}); end
        saw = 1'b0;
        repeat (3) begin @(negedge clk); saw |= out_valid; end
        n_chk++; if (saw !== 1'b0) begin n_err++; $display("FAIL hold_ignored_op got out_valid=%b want=0", saw); end
    endtask

    task automatic test_flush();
        logic [31:0] g_res;
        logic        g_z, g_err, saw;
        int          g_lat;
        @(negedge clk);
        op = 4'd0; bus_a = 32'h2; bus_b = 32'h3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid got=%b want=1", out_valid); end
        flush = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        n_chk++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL flush_done got valid,rdy=%b want=01", {out_valid, in_ready}); end
        flush = 1'b1; in_valid = 1'b1; op = 4'd6; bus_a = 32'h1; bus_b = 32'h2;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL flush_vs_accept got valid,rdy=%b want=01", {out_valid, in_ready}); end
        op = 4'd2; bus_a = 32'h1; bus_b = 32'd10; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        saw = 1'b0;
        repeat (15) begin @(negedge clk); saw |= out_valid; end
        n_chk++; if (saw !== 1'b0) begin n_err++; $display("FAIL flush_mid_shift got out_valid=%b want=0", saw); end
        run_op(4'd3, 32'hF000_0000, 32'd2, g_res, g_z, g_err, g_lat);
        n_chk++; if (g_res !== 32'h3C00_0000) begin n_err++; $display("FAIL flush_after_op got=%h want=3c000000", g_res); end
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] g_res;
        logic        g_z, g_err, saw;
        int          g_lat;
        run_op(4'd0, 32'd2, 32'd3, g_res, g_z, g_err, g_lat);
        n_chk++; if (g_res !== 32'd5) begin n_err++; $display("FAIL rst_mid_pre got=%h want=5", g_res); end
        @(negedge clk);
        op = 4'd2; bus_a = 32'h1; bus_b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1 rstN = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, out, Z, error} !== {1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_shift got valid=%b out=%h Z=%b err=%b want 0 0 0 0", out_valid, out, Z, error);
        end
        @(negedge clk);
        rstN = 1'b1;
        saw = 1'b0;
        repeat (25) begin @(negedge clk); saw |= out_valid; end
        n_chk++; if ({saw, in_ready} !== 2'b01) begin n_err++; $display("FAIL rst_mid_after got valid,rdy=%b want=01", {saw, in_ready}); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [3:0]  o;
        logic [31:0] a, b, g_res;
        logic        g_z, g_err;
        int          g_lat;
        for (int i = 0; i < 24; i++) begin
            o = 4'($urandom_range(0, 12));
            a = $urandom;
            b = $urandom;
            if (i % 6 == 0) b = a;
            if (o >= 4'd2 && o <= 4'd4) b = (b & 32'hFFFF_FFE0) | 32'($urandom_range(0, 7));
            sb_q.push_back(model(o, a, b));
            run_op(o, a, b, g_res, g_z, g_err, g_lat);
            e = sb_q.pop_front();
            n_chk++;
            if ({g_res, g_z, g_err} !== {e.res, e.z, e.err} || g_lat != e.lat) begin
                n_err++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h got out=%h Z=%b err=%b lat=%0d want out=%h Z=%b err=%b lat=%0d",
                         i, o, a, b, g_res, g_z, g_err, g_lat, e.res, e.z, e.err, e.lat);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_hold();
        test_flush();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
